// File: rtl/sp_sram_pkg.sv
// Shared constants and word types for the single-port SRAM model.
// Optional feature macro: SPSRAM_ASYNC_RD_EN (combinational read path).
package sp_sram_pkg;

    localparam int BW_DATA_DEFAULT = 32;
    localparam int BW_ADDR_DEFAULT = 4;
    localparam int DEPTH           = 1 << BW_ADDR_DEFAULT;

    typedef logic [BW_DATA_DEFAULT-1:0] data_t;
    typedef logic [BW_ADDR_DEFAULT-1:0] addr_t;

endpackage : sp_sram_pkg

// File: rtl/sp_sram_rdport.sv
// Read port of the single-port SRAM: forces the read data to zero on
// non-read cycles and optionally registers it.
// Macro SPSRAM_ASYNC_RD_EN selects the combinational read path; the
// default build registers the read data with one cycle of latency.
module sp_sram_rdport
    import sp_sram_pkg::*;
#(
    parameter int BW_DATA = BW_DATA_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_rd,
    input  logic [BW_DATA-1:0] i_word,
    output logic [BW_DATA-1:0] o_data
);

    logic [BW_DATA-1:0] rdData_d;

    // Word selected for output this cycle: array data on a read, zero otherwise
    always_comb begin
        rdData_d = '0;
        if (i_rd) begin
            rdData_d = i_word;
        end
    end

`ifdef SPSRAM_ASYNC_RD_EN
    // The clock is only needed by the registered read path
    logic unusedClk;
    assign unusedClk = i_clk;

    // Combinational read, held at zero while reset is asserted
    always_comb begin
        o_data = '0;
        if (i_rstn) begin
            o_data = rdData_d;
        end
    end
`else
    logic [BW_DATA-1:0] rdData_q;

    // Registered read data, cleared immediately by reset
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rdData_q <= '0;
        end else begin
            rdData_q <= rdData_d;
        end
    end

    assign o_data = rdData_q;
`endif

endmodule : sp_sram_rdport

// File: rtl/sp_sram.sv
// Single-port synchronous-write SRAM: one address bus shared by reads and
// writes. Holds the storage array and write logic; the read path lives in
// sp_sram_rdport. Macro SPSRAM_ASYNC_RD_EN selects a combinational read.
module sp_sram
    import sp_sram_pkg::*;
#(
    parameter int BW_DATA = BW_DATA_DEFAULT,
    parameter int BW_ADDR = BW_ADDR_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    output logic [BW_DATA-1:0] o_data,
    input  logic [BW_DATA-1:0] i_data,
    input  logic [BW_ADDR-1:0] i_addr,
    input  logic               i_wen,
    input  logic               i_cen,
    input  logic               i_oen
);

    localparam int MemDepth = 1 << BW_ADDR;

    logic [BW_DATA-1:0] mem [MemDepth];
    logic               rdEn;
    logic               wrEn;
    logic [BW_DATA-1:0] memWord;

    // A read needs the chip enabled, no write and the output enabled;
    // a write ignores the output enable and is blocked during reset
    always_comb begin
        rdEn    = i_cen & ~i_wen & i_oen;
        wrEn    = i_cen & i_wen & i_rstn;
        memWord = mem[i_addr];
    end

    // Storage array; contents are intentionally not reset
    always_ff @(posedge i_clk) begin
        if (wrEn) begin
            mem[i_addr] <= i_data;
        end
    end

    sp_sram_rdport #(
        .BW_DATA (BW_DATA)
    ) u_rdport (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_rd   (rdEn),
        .i_word (memWord),
        .o_data (o_data)
    );

endmodule : sp_sram

// File: tb/tb_sp_sram.sv
// Directed self-checking bench for sp_sram; builds with or without
// SPSRAM_ASYNC_RD_EN and adjusts its sampling point to the read latency.
module tb_sp_sram;

    logic        clk;
    logic        rstn;
    logic [31:0] oData;
    logic [31:0] iData;
    logic [3:0]  iAddr;
    logic        iWen;
    logic        iCen;
    logic        iOen;

    int testsRun;
    int testsFailed;

    sp_sram #(
        .BW_DATA (32),
        .BW_ADDR (4)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .o_data (oData),
        .i_data (iData),
        .i_addr (iAddr),
        .i_wen  (iWen),
        .i_cen  (iCen),
        .i_oen  (iOen)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one access on the falling edge
    task automatic applyStimulus(input logic cen, input logic wen, input logic oen,
                                 input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        iCen  = cen;
        iWen  = wen;
        iOen  = oen;
        iAddr = addr;
        iData = data;
    endtask

    // Wait until the result of the access just driven is visible
    task automatic waitSample();
`ifdef SPSRAM_ASYNC_RD_EN
        #1;
`else
        @(posedge clk);
        #1;
`endif
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, i[3:0], 32'h0);
            waitSample();
            testsRun++;
            if (oData !== 32'h0) begin
                testsFailed++;
                $display("[TB] FAIL reset_hold cycle %0d: got %h expected %h", i, oData, 32'h0);
            end
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_write_read();
        logic [31:0] exp;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, k[3:0], k);
        end
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, k[3:0], 32'h0);
            waitSample();
            exp = k;
            testsRun++;
            if (oData !== exp) begin
                testsFailed++;
                $display("[TB] FAIL write_read addr %0d: got %h expected %h", k, oData, exp);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        logic [4:0]  wideAddr;
        for (int i = 0; i < 32; i++) begin
            wideAddr = i[4:0];
            applyStimulus(1'b1, 1'b1, 1'b1, wideAddr[3:0], i);
        end
        for (int k = 0; k < 32; k++) begin
            wideAddr = k[4:0];
            applyStimulus(1'b1, 1'b0, 1'b1, wideAddr[3:0], 32'h0);
            waitSample();
            exp = (k % 16) + 16;
            testsRun++;
            if (oData !== exp) begin
                testsFailed++;
                $display("[TB] FAIL wrap read %0d: got %h expected %h", k, oData, exp);
            end
        end
    endtask

    task automatic test_gating();
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd3, 32'hDEADBEEF);
        waitSample();
        testsRun++;
        if (oData !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL gate_write_cycle: got %h expected %h", oData, 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd3, 32'h0);
        waitSample();
        testsRun++;
        if (oData !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL gate_oen0: got %h expected %h", oData, 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd3, 32'h0);
        waitSample();
        testsRun++;
        if (oData !== 32'hDEADBEEF) begin
            testsFailed++;
            $display("[TB] FAIL gate_read_before_cen0: got %h expected %h", oData, 32'hDEADBEEF);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd3, 32'h0);
        waitSample();
        testsRun++;
        if (oData !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL gate_cen0: got %h expected %h", oData, 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd3, 32'h0);
        waitSample();
        testsRun++;
        if (oData !== 32'hDEADBEEF) begin
            testsFailed++;
            $display("[TB] FAIL gate_enabled: got %h expected %h", oData, 32'hDEADBEEF);
        end
    endtask

    task automatic test_idle();
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd3, 32'h12345678);
        waitSample();
        testsRun++;
        if (oData !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL idle_output: got %h expected %h", oData, 32'h0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd3, 32'h0);
        waitSample();
        testsRun++;
        if (oData !== 32'hDEADBEEF) begin
            testsFailed++;
            $display("[TB] FAIL idle_no_write: got %h expected %h", oData, 32'hDEADBEEF);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd4, 32'h0);
        waitSample();
        testsRun++;
        if (oData !== 32'h14) begin
            testsFailed++;
            $display("[TB] FAIL idle_neighbour: got %h expected %h", oData, 32'h14);
        end
    endtask

    task automatic test_reset_mid_op();
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd3, 32'h0);
        waitSample();
        testsRun++;
        if (oData !== 32'hDEADBEEF) begin
            testsFailed++;
            $display("[TB] FAIL rst_pre_read: got %h expected %h", oData, 32'hDEADBEEF);
        end
        #1;
        rstn = 1'b0;
        #1;
        testsRun++;
        if (oData !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL rst_immediate_clear: got %h expected %h", oData, 32'h0);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd3, 32'h0BADF00D);
        @(posedge clk);
        #1;
        testsRun++;
        if (oData !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL rst_hold_during_write: got %h expected %h", oData, 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd3, 32'h0);
        rstn = 1'b1;
        waitSample();
        testsRun++;
        if (oData !== 32'hDEADBEEF) begin
            testsFailed++;
            $display("[TB] FAIL rst_dropped_write: got %h expected %h", oData, 32'hDEADBEEF);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd15, 32'h0);
        waitSample();
        testsRun++;
        if (oData !== 32'h1F) begin
            testsFailed++;
            $display("[TB] FAIL rst_mem_kept: got %h expected %h", oData, 32'h1F);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rstn  = 1'b0;
        iCen  = 1'b1;
        iWen  = 1'b0;
        iOen  = 1'b1;
        iAddr = 4'd0;
        iData = 32'h0;
`ifdef SPSRAM_ASYNC_RD_EN
        $display("[TB] combinational read build");
`else
        $display("[TB] registered read build");
`endif
        test_reset();
        test_write_read();
        test_wrap();
        test_gating();
        test_idle();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule : tb_sp_sram
